distribute_tree_mcast_sched: RTL and testbench
==============================================

Name: distribute_tree_mcast_sched

Overview:
- Sequencer that drives the root of a binary distribution tree built from 1x2 cmd-flow distribute stages, one single-bit destination tag per stage.
- Accepts one data word plus a multicast leaf mask per handshake.
- Serializes the mask into successive unicast issues, one leaf per cycle, each carrying the full destination command.
- Sits between the upstream buffer and the tree root; owns the tree's valid/enable.

Parameters:
- DATA_WIDTH, 32, payload width.
- LEVELS, 2, tree depth; root command width = LEVELS.
- NUM_LEAF, 2**LEVELS, derived localparam; leaf mask width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- i_valid  input  1  upstream word/mask valid.
- o_ready  output  1  scheduler can accept this cycle.
- i_data  input  DATA_WIDTH  payload.
- i_mask  input  NUM_LEAF  destination leaf bitmap; bit k = leaf k.
- i_stall  input  1  downstream freeze request.
- o_valid  output  1  to tree root i_valid.
- o_en  output  1  to tree root i_en.
- o_data  output  DATA_WIDTH  to tree root i_data_bus.
- o_cmd  output  LEVELS  to tree root i_cmd; MSB = root stage tag (1 = high branch).
- o_busy  output  1  sequence in progress.
- o_err_empty  output  1  one-cycle pulse when a zero mask was accepted.

Behaviour:
- Reset values: o_valid=0, o_busy=0, o_err_empty=0, o_cmd=0, o_data=0, internal mask register=0, state IDLE. o_ready=1 and o_en=1 unless i_stall is high.
- Reset asserted mid-sequence aborts the sequence; the remaining leaves are discarded and never issued.
- States:
  - IDLE: o_ready=1. On i_valid and a nonzero i_mask, latch i_data and i_mask, then go to ISSUE. On a zero mask, pulse o_err_empty the next cycle and stay in IDLE.
  - ISSUE: o_valid=1 when not stalled. o_cmd = index of the lowest set bit of the remaining mask (unsigned, LEVELS bits). o_data = latched word. Each non-stalled cycle clears that bit.
- Latency: first issue appears in the cycle after acceptance. A mask with N set bits takes N non-stalled cycles. Issue order is ascending leaf index.
- o_ready in ISSUE is 1 only when the remaining mask has exactly one bit set and i_stall=0. This permits back-to-back acceptance with no bubble. A new accept in that cycle reloads data and mask and stays in ISSUE; otherwise the block returns to IDLE.
- i_stall=1 has these effects:
  - o_valid=0 and o_en=0.
  - The remaining mask and latched data are held.
  - o_ready=0.
  - o_cmd keeps its value.
  - The combinational path from i_stall to o_ready, o_valid and o_en is allowed.
- o_busy = (state==ISSUE).
- A zero mask accepted back-to-back from ISSUE pulses o_err_empty and returns to IDLE.
- o_cmd, o_data and o_valid are decoded from registered state only; there is no combinational path from i_mask or i_data.

Optional Feature:
- Macro: DISTRIBUTE_SCHED_PERF_CNT_EN.
- When defined, the block adds output o_issue_cnt [31:0].
  - Counts every cycle with o_valid=1.
  - Wraps modulo 2^32.
  - Cleared by rst.
- When undefined, the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package distribute_pkg holds:
  - State encoding constants IDLE=1'b0 and ISSUE=1'b1.
  - Function clog2 and a leaf-count helper (2**LEVELS).
  - Tag polarity constant TAG_HIGH=1'b1.
- One sub-module, distribute_lsb_prio_enc, parameterised by NUM_LEAF. It outputs:
  - the index of the lowest set bit;
  - a one-hot clear vector;
  - a single_left flag (exactly one bit set);
  - a none flag.

Test Plan (LEVELS=2, DATA_WIDTH=32):
- Reset: rst=1 mid-cycle with no clk edge → o_valid=0, o_busy=0, o_ready=1, o_cmd=2'b00 immediately; o_issue_cnt=0 when enabled.
- Unicast: accept i_mask=4'b0100, i_data=32'hAAAAAAAA → next cycle shows o_valid=1, o_cmd=2'b10, o_data=32'hAAAAAAAA for exactly 1 cycle, o_ready=1 that cycle.
- Multicast: i_mask=4'b1011 → o_cmd 00, 01, 11 on 3 consecutive cycles; o_ready=0, 0, 1; then IDLE.
- Back-to-back: 4'b0001/32'h11111111 then 4'b1000/32'h22222222 → cmd 00 then 11 on adjacent cycles, data switching at the same time, no bubble.
- Stall: i_mask=4'b1111, i_stall=1 for 2 cycles starting at the 2nd issue → o_valid=0, o_en=0 during the stall; cmd sequence 00, (hold), (hold), 01, 10, 11; exactly 4 valid cycles (o_issue_cnt=4 when enabled).
- Error and abort:
  - i_mask=0 → o_err_empty=1 for 1 cycle, no o_valid.
  - Then i_mask=4'b1111 with rst pulsed after the first issue → outputs at reset values and no further o_valid after rst release.

Source files
------------

// File: rtl/distribute_pkg.sv
// Shared definitions for the multicast distribution-tree scheduler: state
// encoding, sizing helpers and branch tag polarity.
package distribute_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // A set tag bit steers a tree stage to its high branch.
    localparam logic TAG_HIGH = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int leaf_count(input int levels);
        return 1 << levels;
    endfunction

endpackage

// File: rtl/distribute_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot clear vector, and
// single/none population flags for the remaining leaf mask.
module distribute_lsb_prio_enc
    import distribute_pkg::*;
#(
    parameter int NUM_LEAF = 4,
    localparam int IDX_W   = (clog2(NUM_LEAF) < 1) ? 1 : clog2(NUM_LEAF)
) (
    input  logic [NUM_LEAF-1:0] mask,
    output logic [IDX_W-1:0]    idx,
    output logic [NUM_LEAF-1:0] clr,
    output logic                single_left,
    output logic                none
);

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx = '0;
        for (int i = NUM_LEAF - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign clr         = mask & (~mask + NUM_LEAF'(1));
    assign none        = (mask == '0);
    assign single_left = !none && ((mask & (mask - NUM_LEAF'(1))) == '0);

endmodule

// File: rtl/distribute_tree_mcast_sched.sv
// Root sequencer for a binary distribution tree: serializes a multicast leaf
// mask into ascending unicast issues. Optional DISTRIBUTE_SCHED_PERF_CNT_EN adds o_issue_cnt.
module distribute_tree_mcast_sched
    import distribute_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  LEVELS     = 2,
    localparam int NUM_LEAF   = leaf_count(LEVELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [NUM_LEAF-1:0]   i_mask,
    input  logic                  i_stall,
    output logic                  o_valid,
    output logic                  o_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [LEVELS-1:0]     o_cmd,
    output logic                  o_busy,
    output logic                  o_err_empty
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
   ,output logic [31:0]           o_issue_cnt
`endif
);

    state_e                state_q, state_d;
    logic [NUM_LEAF-1:0]   mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic [LEVELS-1:0]     lsb_idx;
    logic [NUM_LEAF-1:0]   lsb_clr;
    logic                  single_left;
    logic                  mask_none;
    logic                  accept;

    distribute_lsb_prio_enc #(.NUM_LEAF(NUM_LEAF)) u_enc (
        .mask        (mask_q),
        .idx         (lsb_idx),
        .clr         (lsb_clr),
        .single_left (single_left),
        .none        (mask_none)
    );

    // Ready in ISSUE only on the final leaf, giving bubble-free chaining.
    assign o_ready     = !i_stall && ((state_q == IDLE) || single_left);
    assign accept      = i_valid && o_ready;
    assign o_valid     = (state_q == ISSUE) && !mask_none && !i_stall;
    assign o_en        = !i_stall;
    assign o_busy      = (state_q == ISSUE);
    assign o_cmd       = lsb_idx;
    assign o_data      = data_q;
    assign o_err_empty = err_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_mask != '0) begin
                        mask_d  = i_mask;
                        data_d  = i_data;
                        state_d = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!i_stall) begin
                    mask_d = mask_q & ~lsb_clr;
                    if (single_left) begin
                        state_d = IDLE;
                        if (accept) begin
                            if (i_mask != '0) begin
                                mask_d  = i_mask;
                                data_d  = i_data;
                                state_d = ISSUE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          o_issue_cnt <= '0;
        else if (o_valid) o_issue_cnt <= o_issue_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_distribute_tree_mcast_sched.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed sequences with hand-computed expectations.
module tb_distribute_tree_mcast_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [3:0]  i_mask = '0;
    logic        i_stall = 1'b0;
    logic        o_valid;
    logic        o_en;
    logic [31:0] o_data;
    logic [1:0]  o_cmd;
    logic        o_busy;
    logic        o_err_empty;
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
    logic [31:0] o_issue_cnt;
`endif

    distribute_tree_mcast_sched #(.DATA_WIDTH(32), .LEVELS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_mask      (i_mask),
        .i_stall     (i_stall),
        .o_valid     (o_valid),
        .o_en        (o_en),
        .o_data      (o_data),
        .o_cmd       (o_cmd),
        .o_busy      (o_busy),
        .o_err_empty (o_err_empty)
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
       ,.o_issue_cnt (o_issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending leaves in issue order, latched word, error pulse, issue count.
    int          m_q[$];
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_cnt = '0;
    int          obs_cmd[$];
    logic [31:0] obs_data[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_err = 1'b0;
            m_cnt = '0;
        end else begin
            logic rdy, fire;
            rdy  = !i_stall && (m_q.size() <= 1);
            fire = !i_stall && (m_q.size() > 0);
            if (fire) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 1;
            end
            m_err = 1'b0;
            if (i_valid && rdy) begin
                if (i_mask == 4'b0000) begin
                    m_err = 1'b1;
                end else begin
                    m_q.delete();
                    m_data = i_data;
                    for (int k = 0; k < 4; k++) if (i_mask[k]) m_q.push_back(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("valid", o_valid, (m_q.size() > 0) && !i_stall);
            check("ready", o_ready, !i_stall && (m_q.size() <= 1));
            check("busy",  o_busy,  m_q.size() > 0);
            check("en",    o_en,    !i_stall);
            check("err",   o_err_empty, m_err);
            if (m_q.size() > 0) begin
                check("cmd",  o_cmd,  m_q[0]);
                check("data", o_data, m_data);
            end
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
            check("cnt", o_issue_cnt, m_cnt);
`endif
            if (o_valid) begin
                obs_cmd.push_back(int'(o_cmd));
                obs_data.push_back(o_data);
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] m, input logic [31:0] d, input logic s);
        @(posedge clk);
        #2;
        i_valid = v;
        i_mask  = m;
        i_data  = d;
        i_stall = s;
        #1;
    endtask

    int exp_multi[3];
    int exp_stall[4];

    initial begin
        exp_multi = '{0, 1, 3};
        exp_stall = '{0, 1, 2, 3};

        // Reset values visible with no clock edge.
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy",  o_busy,  1'b0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_cmd",   o_cmd,   2'b00);
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
        check("rst_cnt", o_issue_cnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Unicast to leaf 2.
        cyc(1'b1, 4'b0100, 32'hAAAAAAAA, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("uni_valid", o_valid, 1'b1);
        check("uni_cmd",   o_cmd,   2'b10);
        check("uni_data",  o_data,  32'hAAAAAAAA);
        check("uni_ready", o_ready, 1'b1);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("uni_done", o_valid, 1'b0);

        // Multicast 1011.
        obs_cmd.delete();
        cyc(1'b1, 4'b1011, 32'h5A5A0001, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("mc_ready0", o_ready, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("mc_ready1", o_ready, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("mc_ready2", o_ready, 1'b1);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("mc_idle", o_busy, 1'b0);
        #3;
        check("mc_count", obs_cmd.size(), 3);
        for (int i = 0; i < 3 && i < obs_cmd.size(); i++) check("mc_order", obs_cmd[i], exp_multi[i]);

        // Back-to-back without a bubble.
        cyc(1'b1, 4'b0001, 32'h11111111, 1'b0);
        cyc(1'b1, 4'b1000, 32'h22222222, 1'b0);
        check("b2b_cmd0",   o_cmd,   2'b00);
        check("b2b_data0",  o_data,  32'h11111111);
        check("b2b_ready0", o_ready, 1'b1);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("b2b_valid1", o_valid, 1'b1);
        check("b2b_cmd1",   o_cmd,   2'b11);
        check("b2b_data1",  o_data,  32'h22222222);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);

        // Stall across the second issue.
        obs_cmd.delete();
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
        begin : cnt_snap
            logic [31:0] c0;
            c0 = o_issue_cnt;
`endif
        cyc(1'b1, 4'b1111, 32'hC0DE0000, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("st_first", o_cmd, 2'b00);
        cyc(1'b0, 4'b0000, 32'h0, 1'b1);
        check("st_valid", o_valid, 1'b0);
        check("st_en",    o_en,    1'b0);
        check("st_ready", o_ready, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b1);
        check("st_valid2", o_valid, 1'b0);
        repeat (4) cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        #3;
        check("st_count", obs_cmd.size(), 4);
        for (int i = 0; i < 4 && i < obs_cmd.size(); i++) check("st_order", obs_cmd[i], exp_stall[i]);
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
            check("st_cnt", o_issue_cnt - c0, 32'd4);
        end
`endif

        // Zero mask error pulse.
        obs_cmd.delete();
        cyc(1'b1, 4'b0000, 32'hDEADBEEF, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("err_pulse", o_err_empty, 1'b1);
        check("err_novalid", o_valid, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("err_clear", o_err_empty, 1'b0);

        // Abort by reset after the first issue.
        cyc(1'b1, 4'b1111, 32'h0BADF00D, 1'b0);
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("ab_first", o_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("ab_valid", o_valid, 1'b0);
        check("ab_busy",  o_busy,  1'b0);
        check("ab_ready", o_ready, 1'b1);
        check("ab_cmd",   o_cmd,   2'b00);
        check("ab_data",  o_data,  32'h0);
`ifdef DISTRIBUTE_SCHED_PERF_CNT_EN
        check("ab_cnt", o_issue_cnt, 32'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        obs_cmd.delete();
        repeat (6) cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        #3;
        check("ab_no_issue", obs_cmd.size(), 0);

        // Randomized traffic against the model.
        repeat (400) begin
            logic [3:0] m;
            m = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            cyc(1'($urandom_range(0, 1)), m, $urandom, ($urandom_range(0, 4) == 0));
        end
        cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        repeat (6) cyc(1'b0, 4'b0000, 32'h0, 1'b0);
        check("end_idle", o_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
